ram16x16_arbiter: RTL and testbench

RAM16X16_ARBITER -- requirements
Module: ram16x16_arbiter

---
 rtl/ram16x16_pkg.sv | 13 +
 rtl/ram16x16_prio_arb.sv | 35 +++
 rtl/ram16x16_arbiter.sv | 95 +++++++++
 tb/tb_ram16x16_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram16x16_pkg.sv
// Shared types and geometry for the 16x16 RAM arbiter slice.
package ram16x16_pkg;

    localparam int RAM_AW    = 4;
    localparam int RAM_DW    = 16;
    localparam int RAM_DEPTH = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/ram16x16_prio_arb.sv
// Read-priority arbiter with a saturating starvation counter for the write port.
module ram16x16_prio_arb #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic wr_req,
    input  logic rd_req,
    output logic wr_grant,
    output logic rd_grant
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              force_wr;

    // A write that has lost MAX_WAIT times wins over a concurrent read.
    assign force_wr = wr_req && (wait_cnt_reg == WAIT_MAX);
    assign wr_grant = enable && wr_req && (force_wr || !rd_req);
    assign rd_grant = enable && rd_req && !force_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (wr_grant) begin
            wait_cnt_reg <= '0;
        end else if (wr_req && (wait_cnt_reg != WAIT_MAX)) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ram16x16_arbiter.sv
// Host-write / display-read arbiter in front of a 16x16 synchronous RAM.
// Define RAM16X16_ARBITER_CLEAR_EN to zero the RAM after reset before serving traffic.
module ram16x16_arbiter
    import ram16x16_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [RAM_DW-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [RAM_DW-1:0] rd_data,
    output logic              init_done,
    output logic              ram_write_en,
    output logic [RAM_AW-1:0] ram_write_addr,
    output logic [RAM_DW-1:0] ram_write_data,
    output logic [RAM_AW-1:0] ram_read_addr,
    input  logic [RAM_DW-1:0] ram_read_data
);

`ifdef RAM16X16_ARBITER_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    state_t            state_reg;
    logic [RAM_AW-1:0] clr_addr_reg;
    logic              init_done_reg;
    logic              rd_valid_reg;
    logic              clear_we;
    logic              wr_grant;
    logic              rd_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_STATE;
            clr_addr_reg  <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (clr_addr_reg == RAM_AW'(RAM_DEPTH - 1)) begin
                        state_reg     <= RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                RUN: init_done_reg <= 1'b1;
            endcase
        end
    end

    // Arbitration only opens once init_done is up, so grants vanish with reset.
    ram16x16_prio_arb #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (init_done_reg),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .wr_grant (wr_grant),
        .rd_grant (rd_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_grant;
        end
    end

    // The sweep owns the write port; rst_n gating keeps it quiet while held in reset.
    assign clear_we       = rst_n && (state_reg == CLEAR);

    assign wr_ack         = wr_grant;
    assign rd_ack         = rd_grant;
    assign rd_valid       = rd_valid_reg;
    assign rd_data        = rd_valid_reg ? ram_read_data : '0;
    assign init_done      = init_done_reg;

    assign ram_write_en   = clear_we || wr_grant;
    assign ram_write_addr = clear_we ? clr_addr_reg : (wr_grant ? wr_addr : '0);
    assign ram_write_data = wr_grant ? wr_data : '0;
    assign ram_read_addr  = rd_grant ? rd_addr : '0;

endmodule

// File: tb/tb_ram16x16_arbiter.sv
// Directed bench for ram16x16_arbiter with a behavioural 16x16 registered-read RAM.
module tb_ram16x16_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        init_done;
    logic        ram_write_en;
    logic [3:0]  ram_write_addr;
    logic [15:0] ram_write_data;
    logic [3:0]  ram_read_addr;
    logic [15:0] ram_read_data;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [16];

    ram16x16_arbiter #(
        .MAX_WAIT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_ack         (rd_ack),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .init_done      (init_done),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
        ram_read_data = 16'h0000;
    end

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        ram_read_data <= mem[ram_read_addr];
    end

    function automatic logic [15:0] pat(input int i);
        logic [15:0] k;
        k = 16'(i);
        return 16'h5A00 ^ (k * 16'h0111);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        wr_req = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF;
        rd_req = 1'b1; rd_addr = 4'd6;
        #1;
        vectors++; if (wr_ack !== 1'b0) begin miscompares++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
        vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL reset_rd_ack got %b want 0", rd_ack); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done got %b want 0", init_done); end
        vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_ram_write_en got %b want 0", ram_write_en); end
        vectors++; if (ram_write_addr !== 4'h0) begin miscompares++; $display("FAIL reset_ram_write_addr got %h want 0", ram_write_addr); end
        vectors++; if (ram_write_data !== 16'h0000) begin miscompares++; $display("FAIL reset_ram_write_data got %h want 0000", ram_write_data); end
        vectors++; if (ram_read_addr !== 4'h0) begin miscompares++; $display("FAIL reset_ram_read_addr got %h want 0", ram_read_addr); end
        wr_req = 1'b0; rd_req = 1'b0;
        next_cycle();
        $display("reset: outputs idle while rst_n low");
    endtask

    task automatic test_release();
        rst_n = 1'b1;
`ifdef RAM16X16_ARBITER_CLEAR_EN
        rd_req = 1'b1; rd_addr = 4'd5;
        for (int i = 0; i < 16; i++) begin
            #1;
            vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("FAIL sweep_en[%0d] got %b want 1", i, ram_write_en); end
            vectors++; if (ram_write_addr !== 4'(i)) begin miscompares++; $display("FAIL sweep_addr[%0d] got %0d want %0d", i, ram_write_addr, i); end
            vectors++; if (ram_write_data !== 16'h0000) begin miscompares++; $display("FAIL sweep_data[%0d] got %h want 0000", i, ram_write_data); end
            vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL sweep_init_done[%0d] got %b want 0", i, init_done); end
            vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL sweep_rd_ack[%0d] got %b want 0", i, rd_ack); end
            next_cycle();
        end
        #1;
        vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL sweep_done_c17 got %b want 1", init_done); end
        vectors++; if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL sweep_first_rd_ack got %b want 1", rd_ack); end
        vectors++; if (ram_read_addr !== 4'd5) begin miscompares++; $display("FAIL sweep_rd_addr got %0d want 5", ram_read_addr); end
        next_cycle();
        rd_req = 1'b0;
        #1;
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL sweep_rd_valid got %b want 1", rd_valid); end
        vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL sweep_rd_data got %h want 0000", rd_data); end
        next_cycle();
        $display("release: clear sweep done, addr 5 reads 0000");
`else
        #1;
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL release_pre_clock_init got %b want 0", init_done); end
        vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("FAIL release_no_sweep got %b want 0", ram_write_en); end
        next_cycle();
        wr_req = 1'b1; wr_addr = 4'd9; wr_data = 16'h0F0F;
        #1;
        vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL release_init_done got %b want 1", init_done); end
        vectors++; if (wr_ack !== 1'b1) begin miscompares++; $display("FAIL release_wr_ack got %b want 1", wr_ack); end
        vectors++; if (ram_write_addr !== 4'd9) begin miscompares++; $display("FAIL release_wr_addr got %0d want 9", ram_write_addr); end
        next_cycle();
        wr_req = 1'b0;
        $display("release: run immediately, write addr 9 acked at once");
`endif
    endtask

    task automatic test_write_read();
        wr_req = 1'b1; wr_addr = 4'd3; wr_data = 16'hA5A5;
        #1;
        vectors++; if (wr_ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack got %b want 1", wr_ack); end
        vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("FAIL wr_en got %b want 1", ram_write_en); end
        vectors++; if (ram_write_addr !== 4'd3) begin miscompares++; $display("FAIL wr_addr got %0d want 3", ram_write_addr); end
        vectors++; if (ram_write_data !== 16'hA5A5) begin miscompares++; $display("FAIL wr_data got %h want a5a5", ram_write_data); end
        next_cycle();
        wr_req = 1'b0;
        rd_req = 1'b1; rd_addr = 4'd3;
        #1;
        vectors++; if (wr_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_pulse got %b want 0", wr_ack); end
        vectors++; if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack got %b want 1", rd_ack); end
        vectors++; if (ram_read_addr !== 4'd3) begin miscompares++; $display("FAIL rd_addr got %0d want 3", ram_read_addr); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_early got %b want 0", rd_valid); end
        next_cycle();
        rd_req = 1'b0;
        #1;
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL rd_valid got %b want 1", rd_valid); end
        vectors++; if (rd_data !== 16'hA5A5) begin miscompares++; $display("FAIL rd_data got %h want a5a5", rd_data); end
        next_cycle();
        #1;
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_pulse got %b want 0", rd_valid); end
        $display("write/read: addr 3 <= a5a5, read back");
    endtask

    task automatic test_starvation();
        wr_req = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
        rd_req = 1'b1; rd_addr = 4'd3;
        for (int k = 1; k <= 4; k++) begin
            #1;
            vectors++; if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL starve_rd_ack[%0d] got %b want 1", k, rd_ack); end
            vectors++; if (wr_ack !== 1'b0) begin miscompares++; $display("FAIL starve_wr_ack[%0d] got %b want 0", k, wr_ack); end
            if (k > 1) begin
                vectors++; if (rd_data !== 16'hA5A5) begin miscompares++; $display("FAIL starve_rd_data[%0d] got %h want a5a5", k, rd_data); end
            end
            next_cycle();
        end
        #1;
        vectors++; if (wr_ack !== 1'b1) begin miscompares++; $display("FAIL forced_wr_ack got %b want 1", wr_ack); end
        vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL forced_rd_ack got %b want 0", rd_ack); end
        vectors++; if (ram_write_addr !== 4'd7) begin miscompares++; $display("FAIL forced_wr_addr got %0d want 7", ram_write_addr); end
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL forced_rd_valid got %b want 1", rd_valid); end
        next_cycle();
        wr_req = 1'b0;
        #1;
        vectors++; if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL resume_rd_ack got %b want 1", rd_ack); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL resume_rd_valid got %b want 0", rd_valid); end
        next_cycle();
        rd_req = 1'b0;
        next_cycle();
        $display("starvation: 4 reads, forced write addr 7, read resumes");
    endtask

    task automatic test_mid_read_reset();
        rd_req = 1'b1; rd_addr = 4'd3;
        #1;
        vectors++; if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL midrst_rd_ack got %b want 1", rd_ack); end
        rst_n = 1'b0;
        #1;
        vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL midrst_ack_drop got %b want 0", rd_ack); end
        vectors++; if (ram_read_addr !== 4'd0) begin miscompares++; $display("FAIL midrst_rd_addr got %0d want 0", ram_read_addr); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL midrst_init_done got %b want 0", init_done); end
        rd_req = 1'b0;
        next_cycle();
        #1;
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_rd_valid got %b want 0", rd_valid); end
        next_cycle();
        rst_n = 1'b1;
`ifdef RAM16X16_ARBITER_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            #1;
            vectors++; if (ram_write_addr !== 4'(i) || ram_write_en !== 1'b1) begin miscompares++; $display("FAIL resweep[%0d] got en %b addr %0d want en 1 addr %0d", i, ram_write_en, ram_write_addr, i); end
            next_cycle();
        end
`else
        #1;
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_rel_rd_valid got %b want 0", rd_valid); end
        next_cycle();
`endif
        #1;
        vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL midrst_reinit got %b want 1", init_done); end
        $display("reset mid-read: ack dropped, no rd_valid, restarted");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            wr_req = 1'b1; wr_addr = 4'(i); wr_data = pat(i);
            #1;
            vectors++; if (wr_ack !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_ack[%0d] got %b want 1", i, wr_ack); end
            next_cycle();
        end
        wr_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd_req = 1'b1; rd_addr = 4'(i % 16);
            #1;
            vectors++; if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL stream_rd_ack[%0d] got %b want 1", i, rd_ack); end
            vectors++; if (rd_valid !== (i > 0)) begin miscompares++; $display("FAIL stream_rd_valid[%0d] got %b want %b", i, rd_valid, (i > 0)); end
            if (i > 0) begin
                vectors++; if (rd_data !== pat((i - 1) % 16)) begin miscompares++; $display("FAIL stream_rd_data[%0d] got %h want %h", i, rd_data, pat((i - 1) % 16)); end
            end
            next_cycle();
        end
        rd_req = 1'b0;
        #1;
        vectors++; if (rd_valid !== 1'b1 || rd_data !== pat(3)) begin miscompares++; $display("FAIL stream_last got valid %b data %h want 1 %h", rd_valid, rd_data, pat(3)); end
        next_cycle();
        #1;
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL stream_end got %b want 0", rd_valid); end
        $display("back-to-back: 16 writes and 20 reads with no bubble");
    endtask

    initial begin
        rst_n = 1'b0;
        wr_req = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
        rd_req = 1'b0; rd_addr = 4'd0;
        test_reset();
        test_release();
        test_write_read();
        test_starvation();
        test_mid_read_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
